systolic_seq_ctrl: RTL and testbench

- Top-level sequencer for the matrix co-accelerator compute pass.
- After a start pulse, it steps through one or more data sets. For each set it produces the accumulate window (input SRAM reads plus array accumulate) and then the drain window.
- It drives the `cycle_num`, `data_set` and `sram_write_enable` inputs of the output write stage, so the quantized array rows land at output SRAM addresses 0..ARRAY_SIZE-1.
- It sits between the host/CSR start interface and the array, input SRAM and write stage.

---
 rtl/systolic_seq_ctrl_pkg.sv | 24 ++
 rtl/systolic_seq_ctrl_if.sv | 43 ++++
 rtl/systolic_seq_ctrl_set_cycle_counter.sv | 64 ++++++
 rtl/systolic_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/systolic_seq_ctrl_pkg.sv
// acc_ctrl_pkg: shared types and constants for the systolic compute-pass sequencer.
//   state_e    : sequencer states (IDLE / RUN / DONE)
//   DATA_SET_W : width of the data-set index
//   CYCLE_W    : width of the per-set cycle index
//   set_len()  : cycles per data set (accumulate + drain + write-stage output register)
package acc_ctrl_pkg;

    localparam int DATA_SET_W = 6;
    localparam int CYCLE_W    = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // The +2 covers the write stage's output register, so the last drained row
    // is committed before the set ends.
    function automatic int unsigned set_len(input int unsigned k_accum_depth,
                                            input int unsigned array_size);
        return k_accum_depth + array_size + 2;
    endfunction

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// systolic_seq_ctrl_if: start/control inputs and array/SRAM/write-stage outputs of the sequencer.
//   master : host side (drives start, num_sets, hold; observes everything else)
//   slave  : sequencer side
// With PERF_CNT_EN defined, perf_cycles / perf_stall are added.
interface systolic_seq_ctrl_if;
    import acc_ctrl_pkg::*;

    logic                  start;
    logic [DATA_SET_W-1:0] num_sets;
    logic                  hold;
    logic                  busy;
    logic                  done;
    logic [DATA_SET_W-1:0] data_set;
    logic [CYCLE_W-1:0]    cycle_num;
    logic                  sram_write_enable;
    logic                  in_sram_rd_en;
    logic [5:0]            in_sram_raddr;
    logic                  array_clear;
    logic                  array_acc_en;
`ifdef PERF_CNT_EN
    logic [31:0]           perf_cycles;
    logic [31:0]           perf_stall;
`endif

    modport master (
        output start, num_sets, hold,
        input  busy, done, data_set, cycle_num, sram_write_enable,
               in_sram_rd_en, in_sram_raddr, array_clear, array_acc_en
`ifdef PERF_CNT_EN
        , input perf_cycles, perf_stall
`endif
    );

    modport slave (
        input  start, num_sets, hold,
        output busy, done, data_set, cycle_num, sram_write_enable,
               in_sram_rd_en, in_sram_raddr, array_clear, array_acc_en
`ifdef PERF_CNT_EN
        , output perf_cycles, perf_stall
`endif
    );

endinterface

// File: rtl/systolic_seq_ctrl_set_cycle_counter.sv
// set_cycle_counter: nested cycle_num / data_set counter for the sequencer.
//   clk, srstn     : clock, synchronous active-low reset
//   clr_i          : force both counters to 0 on the next edge
//   adv_i          : advance by one cycle (wraps cycle_num and bumps data_set at set end)
//   last_set_i     : index of the final data set of the run
//   cycle_num_o    : registered cycle index; cycle_next_o is its next-edge value
//   data_set_o     : registered set index
//   run_end_o      : last cycle of the last set
module set_cycle_counter
    import acc_ctrl_pkg::*;
#(
    parameter int unsigned SET_LEN = 18
)(
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  clr_i,
    input  logic                  adv_i,
    input  logic [DATA_SET_W-1:0] last_set_i,
    output logic [CYCLE_W-1:0]    cycle_num_o,
    output logic [CYCLE_W-1:0]    cycle_next_o,
    output logic [DATA_SET_W-1:0] data_set_o,
    output logic                  run_end_o
);

    localparam logic [CYCLE_W-1:0] LAST_CYCLE = CYCLE_W'(SET_LEN - 1);

    logic [CYCLE_W-1:0]    cycle_q, cycle_d;
    logic [DATA_SET_W-1:0] set_q, set_d;
    logic                  set_end;

    assign set_end   = (cycle_q == LAST_CYCLE);
    assign run_end_o = set_end && (set_q == last_set_i);

    always_comb begin
        cycle_d = cycle_q;
        set_d   = set_q;
        if (clr_i) begin
            cycle_d = '0;
            set_d   = '0;
        end else if (adv_i) begin
            if (set_end) begin
                cycle_d = '0;
                set_d   = set_q + 1'b1;
            end else begin
                cycle_d = cycle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            cycle_q <= '0;
            set_q   <= '0;
        end else begin
            cycle_q <= cycle_d;
            set_q   <= set_d;
        end
    end

    assign cycle_num_o  = cycle_q;
    assign cycle_next_o = cycle_d;
    assign data_set_o   = set_q;

endmodule

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: compute-pass sequencer for the matrix co-accelerator.
// Steps through num_sets data sets; each set is an accumulate window (input SRAM
// reads + array accumulate) followed by the drain into the output write stage.
//   clk, srstn : clock, synchronous active-low reset
//   bus        : systolic_seq_ctrl_if.slave (start/num_sets/hold in; status, SRAM,
//                array and write-stage controls out; all outputs registered)
// Optional: define PERF_CNT_EN to add perf_cycles / perf_stall counters.
//
// state   | meaning
// IDLE    | waiting for start; counters at 0
// RUN     | sequencing sets; cycle_num/data_set advance when hold=0
// DONE    | one-cycle done pulse, then back to IDLE
module systolic_seq_ctrl
    import acc_ctrl_pkg::*;
#(
    parameter int unsigned ARRAY_SIZE    = 8,
    parameter int unsigned K_ACCUM_DEPTH = 8
)(
    input  logic               clk,
    input  logic               srstn,
    systolic_seq_ctrl_if.slave bus
);

    localparam int unsigned        SET_LEN = set_len(K_ACCUM_DEPTH, ARRAY_SIZE);
    localparam logic [CYCLE_W-1:0] K_CYC   = CYCLE_W'(K_ACCUM_DEPTH);

    state_e                state_q, state_d;
    logic [DATA_SET_W-1:0] last_set_q, last_set_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  we_q, we_d;
    logic                  rd_q, rd_d;
    logic                  acc_q, acc_d;
    logic                  clear_q, clear_d;
    logic [5:0]            raddr_q, raddr_d;

    logic                  held, adv, run_end, win;
    logic [CYCLE_W-1:0]    cycle_cur, cycle_next;
    logic [DATA_SET_W-1:0] set_cur;

    assign held = (state_q == ST_RUN) && bus.hold;
    assign adv  = (state_q == ST_RUN) && !bus.hold && !run_end;

    // Counters sit at 0 in IDLE and entering RUN; in DONE they still show the final cycle.
    set_cycle_counter #(.SET_LEN(SET_LEN)) u_cnt (
        .clk          (clk),
        .srstn        (srstn),
        .clr_i        (state_q != ST_RUN),
        .adv_i        (adv),
        .last_set_i   (last_set_q),
        .cycle_num_o  (cycle_cur),
        .cycle_next_o (cycle_next),
        .data_set_o   (set_cur),
        .run_end_o    (run_end)
    );

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_q    <= ST_IDLE;
            last_set_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
            rd_q       <= 1'b0;
            acc_q      <= 1'b0;
            clear_q    <= 1'b0;
            raddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_set_q <= last_set_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            we_q       <= we_d;
            rd_q       <= rd_d;
            acc_q      <= acc_d;
            clear_q    <= clear_d;
            raddr_q    <= raddr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_set_d = last_set_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.num_sets != '0) begin
                        state_d    = ST_RUN;
                        last_set_d = bus.num_sets - 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN:  if (!bus.hold && run_end) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed for the next cycle. A cycle that repeats a frozen
    // cycle_num (the previous RUN cycle was held) gets no read/accumulate/clear,
    // so each accumulate step happens exactly once however long the stall.
    always_comb begin
        win     = (state_d == ST_RUN) && (cycle_next < K_CYC);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
        we_d    = (state_d == ST_RUN);
        rd_d    = win && !held;
        acc_d   = win && !held;
        clear_d = (state_d == ST_RUN) && !held && (cycle_next == '0);
        raddr_d = win ? cycle_next[5:0] : 6'd0;
    end

    assign bus.busy              = busy_q;
    assign bus.done              = done_q;
    assign bus.data_set          = set_cur;
    assign bus.cycle_num         = cycle_cur;
    assign bus.sram_write_enable = we_q;
    assign bus.in_sram_rd_en     = rd_q;
    assign bus.in_sram_raddr     = raddr_q;
    assign bus.array_clear       = clear_q;
    assign bus.array_acc_en      = acc_q;

`ifdef PERF_CNT_EN
    logic [31:0] perf_cycles_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (!srstn) begin
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else if (state_q == ST_IDLE && bus.start) begin
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else if (state_q == ST_RUN) begin
            perf_cycles_q <= perf_cycles_q + 32'd1;
            if (bus.hold) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign bus.perf_cycles = perf_cycles_q;
    assign bus.perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
module tb_systolic_seq_ctrl;

    localparam int K = 8;
    localparam int A = 8;
    localparam int L = K + A + 2;

    logic clk = 1'b0;
    logic srstn;
    int   n_checks = 0;
    int   n_pass   = 0;

    systolic_seq_ctrl_if bus();

    systolic_seq_ctrl #(.ARRAY_SIZE(A), .K_ACCUM_DEPTH(K)) dut (
        .clk   (clk),
        .srstn (srstn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {busy, done, we, rd_en, acc_en, clear, raddr}
    function automatic logic [11:0] obs_flags();
        return {bus.busy, bus.done, bus.sram_write_enable, bus.in_sram_rd_en,
                bus.array_acc_en, bus.array_clear, bus.in_sram_raddr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        n_checks++;
        if (obs_flags() !== 12'd0)
            $display("FAIL %s_flags got %h want %h", name, obs_flags(), 12'd0);
        else n_pass++;
        n_checks++;
        if ({bus.data_set, bus.cycle_num} !== 15'd0)
            $display("FAIL %s_counters got set=%0d cyc=%0d want 0/0", name, bus.data_set, bus.cycle_num);
        else n_pass++;
`ifdef PERF_CNT_EN
        if (name == "reset" || name == "abort") begin
            n_checks++;
            if ({bus.perf_cycles, bus.perf_stall} !== 64'd0)
                $display("FAIL %s_perf got %0d/%0d want 0/0", name, bus.perf_cycles, bus.perf_stall);
            else n_pass++;
        end
`endif
    endtask

    // Reference: the run is the ordered list of (set, cycle) positions p = 0 .. n*L-1.
    // A non-held RUN cycle moves to the next position; a held one repeats it, and a
    // repeated position issues no read/accumulate/clear. After the last position, one DONE cycle.
    // mode: 0 no hold, 1 random hold, 2 hold 4 cycles at position 5.
    task automatic run_seq(input string name, input int n, input int mode,
                           input bit repulse, input int abort_p);
        int p = 0, t = 0, run_cyc = 0, stall_cyc = 0, reads = 0, hcnt = 0;
        int phase, c, s;
        bit fresh = 1'b1;
        bit h;
        logic [11:0] exp_f;
        bus.start    = 1'b1;
        bus.num_sets = 6'(n);
        bus.hold     = 1'($urandom_range(0, 1));
        tick();
        bus.start = 1'b0;
        phase = (n == 0) ? 2 : 1;
        while (phase != 0 && t < 4000) begin
            c = p % L;
            s = p / L;
            if (phase == 1)
                exp_f = {3'b101, 1'(fresh && (c < K)), 1'(fresh && (c < K)),
                         1'(fresh && (c == 0)), (c < K) ? 6'(c) : 6'd0};
            else
                exp_f = {3'b110, 9'd0};
            n_checks++;
            if (obs_flags() !== exp_f)
                $display("FAIL %s_flags t=%0d got %h want %h", name, t, obs_flags(), exp_f);
            else n_pass++;
            if (phase == 1) begin
                n_checks++;
                if ({bus.data_set, bus.cycle_num} !== {6'(s), 9'(c)})
                    $display("FAIL %s_pos t=%0d got set=%0d cyc=%0d want set=%0d cyc=%0d",
                             name, t, bus.data_set, bus.cycle_num, s, c);
                else n_pass++;
            end
            reads += int'(bus.in_sram_rd_en);
            if (phase == 1 && p == abort_p && fresh) begin
                srstn = 1'b0;
                tick();
                srstn = 1'b1;
                check_idle("abort");
                return;
            end
            case (mode)
                1:       h = ($urandom_range(0, 3) == 0);
                2:       h = (p == 5 && hcnt < 4);
                default: h = 1'b0;
            endcase
            if (h) hcnt++;
            bus.hold = (phase == 1) ? h : 1'($urandom_range(0, 1));
            if (repulse && (t == 7 || phase == 2)) begin
                bus.start    = 1'b1;
                bus.num_sets = 6'($urandom_range(1, 63));
            end
            if (phase == 1) begin
                run_cyc++;
                if (h) begin
                    fresh = 1'b0;
                    stall_cyc++;
                end else begin
                    fresh = 1'b1;
                    p++;
                    if (p == n * L) phase = 2;
                end
            end else begin
                phase = 0;
            end
            tick();
            bus.start = 1'b0;
            t++;
        end
        bus.hold = 1'b0;
        if (t >= 4000) begin
            n_checks++;
            $display("FAIL %s_timeout got t=%0d want done", name, t);
        end
        check_idle(name);
        n_checks++;
        if (reads !== n * K)
            $display("FAIL %s_reads got %0d want %0d", name, reads, n * K);
        else n_pass++;
`ifdef PERF_CNT_EN
        n_checks++;
        if (bus.perf_cycles !== 32'(run_cyc) || bus.perf_stall !== 32'(stall_cyc))
            $display("FAIL %s_perf got %0d/%0d want %0d/%0d",
                     name, bus.perf_cycles, bus.perf_stall, run_cyc, stall_cyc);
        else n_pass++;
`endif
    endtask

    task automatic test_reset();
        srstn        = 1'b0;
        bus.start    = 1'b0;
        bus.num_sets = '0;
        bus.hold     = 1'b0;
        repeat (3) tick();
        check_idle("reset");
        srstn = 1'b1;
        tick();
    endtask

    task automatic test_single();      run_seq("single", 1, 0, 1'b0, -1); endtask
    task automatic test_multi();       run_seq("multi", 3, 0, 1'b0, -1);  endtask
    task automatic test_hold();        run_seq("hold", 1, 2, 1'b0, -1);   endtask
    task automatic test_zero_sets();   run_seq("zero", 0, 0, 1'b0, -1);   endtask
    task automatic test_max_sets();    run_seq("max", 63, 0, 1'b0, -1);   endtask
    task automatic test_start_ignored(); run_seq("repulse", 2, 0, 1'b1, -1); endtask

    task automatic test_reset_mid_run();
        run_seq("abort_run", 2, 0, 1'b0, L + 10);
        tick();
        run_seq("after_abort", 2, 0, 1'b0, -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_seq("random", int'($urandom_range(1, 4)), 1, 1'($urandom_range(0, 1)), -1);
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_hold();
        test_zero_sets();
        test_reset_mid_run();
        test_start_ignored();
        test_max_sets();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
